// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester-side handshake and shared SPI pin bundle for the bus arbiter
interface spi_bus_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req, gnt, req_sck, req_mosi, req_cs_n, req_miso, cs_n;
  logic spi_sck, spi_mosi, spi_miso, busy, timeout_irq;
  logic [2:0] timeout_id;
  modport master (
    output req, req_sck, req_mosi, req_cs_n, spi_miso,
    input gnt, req_miso, spi_sck, spi_mosi, cs_n, busy, timeout_irq, timeout_id
  );
  modport slave (
    input req, req_sck, req_mosi, req_cs_n, spi_miso,
    output gnt, req_miso, spi_sck, spi_mosi, cs_n, busy, timeout_irq, timeout_id
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI bus with a CS guard gap and hung-owner revoke
module spi_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GUARD_CYCLES = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int CPOL = 0
) (
  input logic clk,
  input logic rst,
  spi_bus_arbiter_if.slave bus
);
  localparam int TW = TIMEOUT_WIDTH > 0 ? TIMEOUT_WIDTH : 1;
  localparam int GW = GUARD_CYCLES > 0 ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] gnt, block;
  logic [7:0] req_p, sck_p, mosi_p, cs_p, elig;
  logic [2:0] rr_ptr, own, win, idx, irq_id;
  logic found, rel, revoke, gdone, active, prev_sck, prev_cs, irq;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  // zero-extend to 8 so a 3-bit owner index selects cleanly for any NUM_REQ
  assign req_p = 8'(bus.req);
  assign sck_p = 8'(bus.req_sck);
  assign mosi_p = 8'(bus.req_mosi);
  assign cs_p = 8'(bus.req_cs_n);
  assign elig = 8'(bus.req & ~block);
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = 3'((int'(rr_ptr) + i) % NUM_REQ);
      if (elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign active = sck_p[own] != prev_sck || cs_p[own] != prev_cs;
  always_comb begin
    rel = state == GRANT && !req_p[own];
    revoke = state == GRANT && req_p[own] && TIMEOUT_WIDTH > 0 && &tcnt;
    gdone = state == GUARD && gcnt == GW'(GUARD_CYCLES - 1);
    state_n = state == IDLE ? (found ? GRANT : IDLE)
            : (rel || revoke) ? (GUARD_CYCLES == 0 ? IDLE : GUARD)
            : gdone ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      block <= '0;
      rr_ptr <= '0;
      own <= '0;
      tcnt <= '0;
      gcnt <= '0;
      prev_sck <= 1'b0;
      prev_cs <= 1'b1;
      irq <= 1'b0;
      irq_id <= '0;
    end else begin
      state <= state_n;
      block <= (block & bus.req) | (revoke ? NUM_REQ'(8'b1 << own) : '0);
      irq <= revoke;
      if (revoke) irq_id <= own;
      if (state == IDLE && found) begin
        gnt <= NUM_REQ'(8'b1 << win);
        own <= win;
        rr_ptr <= win == LAST ? 3'd0 : win + 3'd1;
      end else if (rel || revoke) gnt <= '0;
      tcnt <= state != GRANT || active ? '0 : tcnt + 1'b1;
      gcnt <= state == GUARD ? gcnt + 1'b1 : '0;
      prev_sck <= sck_p[state == IDLE ? win : own];
      prev_cs <= cs_p[state == IDLE ? win : own];
    end
  end
  // gnt is all-zero outside GRANT, so the pin mux needs no state qualifier
  assign bus.gnt = gnt;
  assign bus.cs_n = ~(gnt & ~bus.req_cs_n);
  assign bus.req_miso = ~(gnt & {NUM_REQ{~bus.spi_miso}});
  assign bus.spi_sck = state == GRANT ? sck_p[own] : 1'(CPOL);
  assign bus.spi_mosi = state == GRANT ? mosi_p[own] : 1'b1;
  assign bus.busy = state != IDLE;
  assign bus.timeout_irq = irq;
  assign bus.timeout_id = irq_id;
endmodule
